// File: rtl/control_fsm.sv
// Multi-cycle MIPS-style control unit: Moore FSM sequencing fetch, decode, execute and exceptions.
// Define MULT_DIV_EN to add mult/div (32-cycle MD_WAIT with HI/LO load), mfhi and mflo.
module control_fsm (
    input  logic       i_clk,
    input  logic       i_reset,
    input  logic [5:0] i_opcode,
    input  logic [5:0] i_funct,
    input  logic       i_alu_overflow,
    input  logic       i_zero,
    input  logic       i_by_zero,
    output logic       o_pc_write,
    output logic       o_mem_write,
    output logic       o_mem_read,
    output logic       o_ir_write,
    output logic       o_reg_write,
    output logic       o_iord,
    output logic       o_alu_src_a,
    output logic       o_epc_write,
    output logic [3:0] o_mem_to_reg,
    output logic [3:0] o_reg_dest,
    output logic [3:0] o_alu_src_b,
    output logic [3:0] o_pc_source,
    output logic [3:0] o_exception,
    output logic [3:0] o_write_src,
    output logic [2:0] o_alu_control,
    output logic       o_hi_write,
    output logic       o_lo_write,
    output logic       o_div_mult
);

    localparam logic [4:0] S_RESET    = 5'd0;
    localparam logic [4:0] S_FETCH1   = 5'd1;
    localparam logic [4:0] S_FETCH2   = 5'd2;
    localparam logic [4:0] S_FETCH3   = 5'd3;
    localparam logic [4:0] S_DECODE   = 5'd4;
    localparam logic [4:0] S_EX_ADD   = 5'd5;
    localparam logic [4:0] S_EX_SUB   = 5'd6;
    localparam logic [4:0] S_EX_AND   = 5'd7;
    localparam logic [4:0] S_EX_ADDI  = 5'd8;
    localparam logic [4:0] S_WB_R     = 5'd9;
    localparam logic [4:0] S_WB_I     = 5'd10;
    localparam logic [4:0] S_LW_ADDR  = 5'd11;
    localparam logic [4:0] S_LW_RD1   = 5'd12;
    localparam logic [4:0] S_LW_RD2   = 5'd13;
    localparam logic [4:0] S_LW_WB    = 5'd14;
    localparam logic [4:0] S_SW_ADDR  = 5'd15;
    localparam logic [4:0] S_SW_WR    = 5'd16;
    localparam logic [4:0] S_BEQ      = 5'd17;
    localparam logic [4:0] S_BNE      = 5'd18;
    localparam logic [4:0] S_JUMP     = 5'd19;
    localparam logic [4:0] S_JR       = 5'd20;
    localparam logic [4:0] S_RTE      = 5'd21;
    localparam logic [4:0] S_EXC1     = 5'd22;
    localparam logic [4:0] S_EXC2     = 5'd23;
    localparam logic [4:0] S_EXC3     = 5'd24;
    localparam logic [4:0] S_EXC4     = 5'd25;
`ifdef MULT_DIV_EN
    localparam logic [4:0] S_MD_WAIT  = 5'd26;
    localparam logic [4:0] S_MD_WRITE = 5'd27;
    localparam logic [4:0] S_MFHI     = 5'd28;
    localparam logic [4:0] S_MFLO     = 5'd29;
`endif

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    localparam logic [5:0] FN_JR    = 6'h08;
    localparam logic [5:0] FN_RTE   = 6'h13;
    localparam logic [5:0] FN_ADD   = 6'h20;
    localparam logic [5:0] FN_SUB   = 6'h22;
    localparam logic [5:0] FN_AND   = 6'h24;
`ifdef MULT_DIV_EN
    localparam logic [5:0] FN_MFHI  = 6'h10;
    localparam logic [5:0] FN_MFLO  = 6'h12;
    localparam logic [5:0] FN_MULT  = 6'h18;
    localparam logic [5:0] FN_DIV   = 6'h1A;
`endif

    localparam logic [2:0] ALU_PASS = 3'b000;
    localparam logic [2:0] ALU_ADD  = 3'b001;
    localparam logic [2:0] ALU_SUB  = 3'b010;
    localparam logic [2:0] ALU_AND  = 3'b011;

    localparam logic [1:0] EXC_NONE   = 2'd0;
    localparam logic [1:0] EXC_BAD_OP = 2'd1;
    localparam logic [1:0] EXC_OVF    = 2'd2;
`ifdef MULT_DIV_EN
    localparam logic [1:0] EXC_DIV0   = 2'd3;
`endif

    logic [4:0] r_state;
    logic [4:0] w_state_d;
    logic [1:0] r_exc_code;
    logic [1:0] w_exc_code_d;

`ifdef MULT_DIV_EN
    logic [4:0] r_md_cnt;
    logic [4:0] w_md_cnt_d;
    logic       r_is_div;
    logic       w_is_div_d;
`else
    logic       w_unused_by_zero;
    assign w_unused_by_zero = i_by_zero;
`endif

    always_comb begin
        w_state_d    = r_state;
        w_exc_code_d = r_exc_code;
        case (r_state)
            S_RESET:   w_state_d = S_FETCH1;
            S_FETCH1:  w_state_d = S_FETCH2;
            S_FETCH2:  w_state_d = S_FETCH3;
            S_FETCH3:  w_state_d = S_DECODE;
            S_DECODE: begin
                case (i_opcode)
                    OP_RTYPE: begin
                        case (i_funct)
                            FN_ADD:  w_state_d = S_EX_ADD;
                            FN_SUB:  w_state_d = S_EX_SUB;
                            FN_AND:  w_state_d = S_EX_AND;
                            FN_JR:   w_state_d = S_JR;
                            FN_RTE:  w_state_d = S_RTE;
`ifdef MULT_DIV_EN
                            FN_MULT, FN_DIV: w_state_d = S_MD_WAIT;
                            FN_MFHI: w_state_d = S_MFHI;
                            FN_MFLO: w_state_d = S_MFLO;
`endif
                            default: w_state_d = S_EXC1;
                        endcase
                    end
                    OP_ADDI: w_state_d = S_EX_ADDI;
                    OP_LW:   w_state_d = S_LW_ADDR;
                    OP_SW:   w_state_d = S_SW_ADDR;
                    OP_BEQ:  w_state_d = S_BEQ;
                    OP_BNE:  w_state_d = S_BNE;
                    OP_J:    w_state_d = S_JUMP;
                    default: w_state_d = S_EXC1;
                endcase
                if (w_state_d == S_EXC1) begin
                    w_exc_code_d = EXC_BAD_OP;
                end
            end
            // Overflow squashes the writeback and diverts to the exception sequence.
            S_EX_ADD, S_EX_SUB, S_EX_ADDI: begin
                if (i_alu_overflow) begin
                    w_state_d    = S_EXC1;
                    w_exc_code_d = EXC_OVF;
                end else begin
                    w_state_d = (r_state == S_EX_ADDI) ? S_WB_I : S_WB_R;
                end
            end
            S_EX_AND:  w_state_d = S_WB_R;
            S_WB_R:    w_state_d = S_FETCH1;
            S_WB_I:    w_state_d = S_FETCH1;
            S_LW_ADDR: w_state_d = S_LW_RD1;
            S_LW_RD1:  w_state_d = S_LW_RD2;
            S_LW_RD2:  w_state_d = S_LW_WB;
            S_LW_WB:   w_state_d = S_FETCH1;
            S_SW_ADDR: w_state_d = S_SW_WR;
            S_SW_WR:   w_state_d = S_FETCH1;
            S_BEQ:     w_state_d = S_FETCH1;
            S_BNE:     w_state_d = S_FETCH1;
            S_JUMP:    w_state_d = S_FETCH1;
            S_JR:      w_state_d = S_FETCH1;
            S_RTE:     w_state_d = S_FETCH1;
            S_EXC1:    w_state_d = S_EXC2;
            S_EXC2:    w_state_d = S_EXC3;
            S_EXC3:    w_state_d = S_EXC4;
            S_EXC4: begin
                w_state_d    = S_FETCH1;
                w_exc_code_d = EXC_NONE;
            end
`ifdef MULT_DIV_EN
            S_MD_WAIT: begin
                if (r_md_cnt == 5'd31) begin
                    if (r_is_div && i_by_zero) begin
                        w_state_d    = S_EXC1;
                        w_exc_code_d = EXC_DIV0;
                    end else begin
                        w_state_d = S_MD_WRITE;
                    end
                end
            end
            S_MD_WRITE: w_state_d = S_FETCH1;
            S_MFHI:     w_state_d = S_FETCH1;
            S_MFLO:     w_state_d = S_FETCH1;
`endif
            default:   w_state_d = S_RESET;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state    <= S_RESET;
            r_exc_code <= EXC_NONE;
        end else begin
            r_state    <= w_state_d;
            r_exc_code <= w_exc_code_d;
        end
    end

`ifdef MULT_DIV_EN
    always_comb begin
        w_md_cnt_d = r_md_cnt;
        w_is_div_d = r_is_div;
        if (r_state == S_DECODE) begin
            w_md_cnt_d = 5'd0;
            w_is_div_d = (i_funct == FN_DIV);
        end else if (r_state == S_MD_WAIT) begin
            w_md_cnt_d = r_md_cnt + 5'd1;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_md_cnt <= 5'd0;
            r_is_div <= 1'b0;
        end else begin
            r_md_cnt <= w_md_cnt_d;
            r_is_div <= w_is_div_d;
        end
    end
`endif

    // Outputs follow the state only (branch PCwrite also looks at Zero); reset forces all low.
    always_comb begin
        o_pc_write    = 1'b0;
        o_mem_write   = 1'b0;
        o_mem_read    = 1'b0;
        o_ir_write    = 1'b0;
        o_reg_write   = 1'b0;
        o_iord        = 1'b0;
        o_alu_src_a   = 1'b0;
        o_epc_write   = 1'b0;
        o_mem_to_reg  = 4'd0;
        o_reg_dest    = 4'd0;
        o_alu_src_b   = 4'd0;
        o_pc_source   = 4'd0;
        o_exception   = 4'd0;
        o_write_src   = 4'd0;
        o_alu_control = ALU_PASS;
        o_hi_write    = 1'b0;
        o_lo_write    = 1'b0;
        o_div_mult    = 1'b0;
        if (!i_reset) begin
            case (r_state)
                S_RESET: begin
                    o_reg_write  = 1'b1;
                    o_reg_dest   = 4'd2;
                    o_mem_to_reg = 4'd3;
                end
                S_FETCH3: begin
                    o_ir_write    = 1'b1;
                    o_alu_src_b   = 4'd1;
                    o_alu_control = ALU_ADD;
                    o_pc_write    = 1'b1;
                end
                S_DECODE: begin
                    o_alu_src_b   = 4'd3;
                    o_alu_control = ALU_ADD;
                end
                S_EX_ADD, S_EX_SUB, S_EX_AND: begin
                    o_alu_src_a   = 1'b1;
                    o_alu_control = (r_state == S_EX_ADD) ? ALU_ADD :
                                    (r_state == S_EX_SUB) ? ALU_SUB : ALU_AND;
                end
                S_EX_ADDI, S_LW_ADDR, S_SW_ADDR: begin
                    o_alu_src_a   = 1'b1;
                    o_alu_src_b   = 4'd2;
                    o_alu_control = ALU_ADD;
                end
                S_WB_R: begin
                    o_reg_write = 1'b1;
                    o_reg_dest  = 4'd1;
                end
                S_WB_I: o_reg_write = 1'b1;
                S_LW_RD1: o_iord = 1'b1;
                S_LW_RD2: begin
                    o_iord     = 1'b1;
                    o_mem_read = 1'b1;
                end
                S_LW_WB: begin
                    o_reg_write  = 1'b1;
                    o_mem_to_reg = 4'd1;
                end
                S_SW_WR: begin
                    o_iord      = 1'b1;
                    o_mem_write = 1'b1;
                end
                S_BEQ, S_BNE: begin
                    o_alu_src_a   = 1'b1;
                    o_alu_control = ALU_SUB;
                    o_pc_source   = 4'd1;
                    o_pc_write    = (r_state == S_BEQ) ? i_zero : !i_zero;
                end
                S_JUMP: begin
                    o_pc_source = 4'd2;
                    o_pc_write  = 1'b1;
                end
                S_JR: begin
                    o_alu_src_a = 1'b1;
                    o_pc_write  = 1'b1;
                end
                S_RTE: begin
                    o_pc_source = 4'd3;
                    o_pc_write  = 1'b1;
                end
                S_EXC1: begin
                    o_alu_src_b   = 4'd1;
                    o_alu_control = ALU_SUB;
                end
                S_EXC2: begin
                    o_epc_write = 1'b1;
                    o_iord      = 1'b1;
                    o_exception = {2'b00, r_exc_code};
                end
                S_EXC3: begin
                    o_iord      = 1'b1;
                    o_exception = {2'b00, r_exc_code};
                    o_mem_read  = 1'b1;
                end
                S_EXC4: begin
                    o_pc_source = 4'd4;
                    o_pc_write  = 1'b1;
                end
`ifdef MULT_DIV_EN
                S_MD_WAIT: o_div_mult = r_is_div;
                S_MD_WRITE: begin
                    o_hi_write = 1'b1;
                    o_lo_write = 1'b1;
                    o_div_mult = r_is_div;
                end
                S_MFHI, S_MFLO: begin
                    o_reg_write = 1'b1;
                    o_reg_dest  = 4'd1;
                    o_write_src = (r_state == S_MFHI) ? 4'd1 : 4'd2;
                end
`endif
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_control_fsm.sv
// Bench for control_fsm: per-instruction event traces compared against a cycle-budget model.
// Honours MULT_DIV_EN the same way the design does.
module tb_control_fsm;

    logic       clk = 1'b0;
    logic       reset;
    logic [5:0] opcode, funct;
    logic       ovf, zero, byz;
    logic       pc_write, mem_write, mem_read, ir_write, reg_write, iord, src_a, epc_write;
    logic [3:0] mem_to_reg, reg_dest, src_b, pc_source, exception, write_src;
    logic [2:0] alu_control;
    logic       hi_write, lo_write, div_mult;

    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    control_fsm dut (
        .i_clk(clk), .i_reset(reset), .i_opcode(opcode), .i_funct(funct),
        .i_alu_overflow(ovf), .i_zero(zero), .i_by_zero(byz),
        .o_pc_write(pc_write), .o_mem_write(mem_write), .o_mem_read(mem_read),
        .o_ir_write(ir_write), .o_reg_write(reg_write), .o_iord(iord),
        .o_alu_src_a(src_a), .o_epc_write(epc_write), .o_mem_to_reg(mem_to_reg),
        .o_reg_dest(reg_dest), .o_alu_src_b(src_b), .o_pc_source(pc_source),
        .o_exception(exception), .o_write_src(write_src), .o_alu_control(alu_control),
        .o_hi_write(hi_write), .o_lo_write(lo_write), .o_div_mult(div_mult)
    );

    // reg_write, reg_dest, mem_to_reg lead so the S_RESET pattern is easy to state.
    wire [37:0] all_out = {reg_write, reg_dest, mem_to_reg, pc_write, mem_write, mem_read,
                           ir_write, iord, src_a, epc_write, src_b, pc_source, exception,
                           write_src, alu_control, hi_write, lo_write, div_mult};

    typedef struct packed {
        logic [63:0] rw, mr, mw, pw, ew, ir, io, hiw, low;
        logic [3:0]  rdst, m2r, wsrc, pcs, exc_ew, exc_mr;
        logic        dm;
        logic [7:0]  dec, ex;
        int          len;
    } trace_t;

    // Expected strobe cycles (1 = FETCH1) and mux values for one instruction.
    function automatic trace_t model(input logic [5:0] op, input logic [5:0] fn,
                                     input logic ov, input logic zr, input logic bz);
        trace_t e;
        int k;
        logic [3:0] code;
        e = '0;
        k = 0;
        code = 4'd0;
        e.pw[3] = 1'b1;
        e.ir[3] = 1'b1;
        e.dec = {1'b0, 4'd3, 3'd1};
        e.len = 5;
        if ((op == 6'h00 && (fn == 6'h20 || fn == 6'h22 || fn == 6'h24)) || op == 6'h08) begin
            if (op == 6'h08)      e.ex = {1'b1, 4'd2, 3'd1};
            else if (fn == 6'h20) e.ex = {1'b1, 4'd0, 3'd1};
            else if (fn == 6'h22) e.ex = {1'b1, 4'd0, 3'd2};
            else                  e.ex = {1'b1, 4'd0, 3'd3};
            if (ov && !(op == 6'h00 && fn == 6'h24)) begin
                k = 6;
                code = 4'd2;
            end else begin
                e.len = 6;
                e.rw[6] = 1'b1;
                e.rdst = (op == 6'h00) ? 4'd1 : 4'd0;
            end
        end else if (op == 6'h00 && fn == 6'h08) begin
            e.ex = {1'b1, 4'd0, 3'd0};
            e.pw[5] = 1'b1;
        end else if (op == 6'h00 && fn == 6'h13) begin
            e.pw[5] = 1'b1;
            e.pcs = 4'd3;
        end else if (op == 6'h02) begin
            e.pw[5] = 1'b1;
            e.pcs = 4'd2;
        end else if (op == 6'h04 || op == 6'h05) begin
            e.ex = {1'b1, 4'd0, 3'd2};
            if ((op == 6'h04) == zr) begin
                e.pw[5] = 1'b1;
                e.pcs = 4'd1;
            end
        end else if (op == 6'h23) begin
            e.ex = {1'b1, 4'd2, 3'd1};
            e.len = 8;
            e.io[6] = 1'b1;
            e.io[7] = 1'b1;
            e.mr[7] = 1'b1;
            e.rw[8] = 1'b1;
            e.m2r = 4'd1;
        end else if (op == 6'h2B) begin
            e.ex = {1'b1, 4'd2, 3'd1};
            e.len = 6;
            e.io[6] = 1'b1;
            e.mw[6] = 1'b1;
`ifdef MULT_DIV_EN
        end else if (op == 6'h00 && (fn == 6'h18 || fn == 6'h1A)) begin
            if (fn == 6'h1A && bz) begin
                k = 37;
                code = 4'd3;
            end else begin
                e.len = 37;
                e.hiw[37] = 1'b1;
                e.low[37] = 1'b1;
                e.dm = (fn == 6'h1A);
            end
        end else if (op == 6'h00 && (fn == 6'h10 || fn == 6'h12)) begin
            e.rw[5] = 1'b1;
            e.rdst = 4'd1;
            e.wsrc = (fn == 6'h10) ? 4'd1 : 4'd2;
`endif
        end else begin
            k = 5;
            code = 4'd1;
        end
        if (k != 0) begin
            if (k == 5) e.ex = {1'b0, 4'd1, 3'd2};
            e.ew[k+1] = 1'b1;
            e.io[k+1] = 1'b1;
            e.io[k+2] = 1'b1;
            e.mr[k+2] = 1'b1;
            e.pw[k+3] = 1'b1;
            e.pcs = 4'd4;
            e.exc_ew = code;
            e.exc_mr = code;
            e.len = k + 3;
        end
        if (bz && !bz) e.len = 0;
        return e;
    endfunction

    task automatic tick;
        @(posedge clk);
        #2;
    endtask

    // Expects the DUT to enter FETCH1 at the next edge; leaves it about to enter the next FETCH1.
    task automatic run_instr(input string name, input logic [5:0] op, input logic [5:0] fn,
                             input logic ov, input logic zr, input logic bz);
        trace_t e, o;
        e = model(op, fn, ov, zr, bz);
        o = '0;
        opcode = op;
        funct = fn;
        ovf = ov;
        zero = zr;
        byz = bz;
        for (int c = 1; c <= e.len; c++) begin
            tick();
            if (c <= 2) begin
                vectors++;
                if (all_out !== 38'd0) begin
                    miscompares++;
                    $display("FAIL %s fetch%0d outputs: got %h want 0", name, c, all_out);
                end
            end
            if (reg_write) begin
                o.rw[c] = 1'b1;
                o.rdst = reg_dest;
                o.m2r = mem_to_reg;
                o.wsrc = write_src;
            end
            if (mem_read) begin
                o.mr[c] = 1'b1;
                o.exc_mr = exception;
            end
            if (pc_write) begin
                o.pw[c] = 1'b1;
                o.pcs = pc_source;
            end
            if (epc_write) begin
                o.ew[c] = 1'b1;
                o.exc_ew = exception;
            end
            if (hi_write) begin
                o.hiw[c] = 1'b1;
                o.dm = div_mult;
            end
            if (lo_write) o.low[c] = 1'b1;
            if (mem_write) o.mw[c] = 1'b1;
            if (ir_write) o.ir[c] = 1'b1;
            if (iord) o.io[c] = 1'b1;
            if (c == 4) o.dec = {src_a, src_b, alu_control};
            if (c == 5) o.ex = {src_a, src_b, alu_control};
        end
        vectors++;
        if ({o.rw, o.mr, o.mw, o.pw, o.ew} !== {e.rw, e.mr, e.mw, e.pw, e.ew}) begin
            miscompares++;
            $display("FAIL %s strobes rw/mr/mw/pw/ew: got %h want %h", name,
                     {o.rw, o.mr, o.mw, o.pw, o.ew}, {e.rw, e.mr, e.mw, e.pw, e.ew});
        end
        vectors++;
        if ({o.ir, o.io, o.hiw, o.low} !== {e.ir, e.io, e.hiw, e.low}) begin
            miscompares++;
            $display("FAIL %s strobes ir/iord/hi/lo: got %h want %h", name,
                     {o.ir, o.io, o.hiw, o.low}, {e.ir, e.io, e.hiw, e.low});
        end
        vectors++;
        if ({o.rdst, o.m2r, o.wsrc, o.pcs, o.exc_ew, o.exc_mr, o.dm} !==
            {e.rdst, e.m2r, e.wsrc, e.pcs, e.exc_ew, e.exc_mr, e.dm}) begin
            miscompares++;
            $display("FAIL %s selects rdst/m2r/wsrc/pcs/exc/excmr/dm: got %h want %h", name,
                     {o.rdst, o.m2r, o.wsrc, o.pcs, o.exc_ew, o.exc_mr, o.dm},
                     {e.rdst, e.m2r, e.wsrc, e.pcs, e.exc_ew, e.exc_mr, e.dm});
        end
        vectors++;
        if ({o.dec, o.ex} !== {e.dec, e.ex}) begin
            miscompares++;
            $display("FAIL %s alu decode/exec: got %h want %h", name, {o.dec, o.ex},
                     {e.dec, e.ex});
        end
    endtask

    task automatic test_reset;
        reset = 1'b1;
        opcode = 6'h00;
        funct = 6'h20;
        ovf = 1'b0;
        zero = 1'b0;
        byz = 1'b0;
        repeat (3) begin
            tick();
            vectors++;
            if (all_out !== 38'd0) begin
                miscompares++;
                $display("FAIL reset_hold outputs: got %h want 0", all_out);
            end
        end
        reset = 1'b0;
        #1;
        vectors++;
        if (all_out !== {1'b1, 4'd2, 4'd3, 29'd0}) begin
            miscompares++;
            $display("FAIL reset_release outputs: got %h want %h", all_out,
                     {1'b1, 4'd2, 4'd3, 29'd0});
        end
    endtask

    task automatic test_alu;
        run_instr("add", 6'h00, 6'h20, 1'b0, 1'b0, 1'b0);
        run_instr("add_ovf", 6'h00, 6'h20, 1'b1, 1'b0, 1'b0);
        run_instr("sub_ovf", 6'h00, 6'h22, 1'b1, 1'b1, 1'b0);
        run_instr("and_ovf_ignored", 6'h00, 6'h24, 1'b1, 1'b0, 1'b0);
        run_instr("addi", 6'h08, 6'h00, 1'b0, 1'b0, 1'b0);
        run_instr("addi_ovf", 6'h08, 6'h3F, 1'b1, 1'b0, 1'b0);
    endtask

    task automatic test_branch_jump;
        run_instr("beq_taken", 6'h04, 6'h00, 1'b0, 1'b1, 1'b0);
        run_instr("beq_not", 6'h04, 6'h00, 1'b0, 1'b0, 1'b0);
        run_instr("bne_zero", 6'h05, 6'h00, 1'b0, 1'b1, 1'b0);
        run_instr("bne_taken", 6'h05, 6'h00, 1'b0, 1'b0, 1'b0);
        run_instr("j", 6'h02, 6'h11, 1'b0, 1'b0, 1'b0);
        run_instr("jr", 6'h00, 6'h08, 1'b0, 1'b0, 1'b0);
        run_instr("rte", 6'h00, 6'h13, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic test_mem;
        run_instr("lw", 6'h23, 6'h05, 1'b0, 1'b0, 1'b0);
        run_instr("sw", 6'h2B, 6'h00, 1'b0, 1'b0, 1'b0);
        run_instr("lw_ovf_ignored", 6'h23, 6'h00, 1'b1, 1'b0, 1'b0);
    endtask

    task automatic test_illegal;
        run_instr("op3f", 6'h3F, 6'h00, 1'b0, 1'b0, 1'b0);
        run_instr("rtype_bad_funct", 6'h00, 6'h3F, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic test_mul_div;
        run_instr("mult", 6'h00, 6'h18, 1'b0, 1'b0, 1'b0);
        run_instr("div", 6'h00, 6'h1A, 1'b0, 1'b0, 1'b0);
        run_instr("div_by_zero", 6'h00, 6'h1A, 1'b0, 1'b0, 1'b1);
        run_instr("mfhi", 6'h00, 6'h10, 1'b0, 1'b0, 1'b0);
        run_instr("mflo", 6'h00, 6'h12, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic test_reset_in_exc;
        opcode = 6'h3F;
        funct = 6'h00;
        ovf = 1'b0;
        zero = 1'b0;
        byz = 1'b0;
        repeat (6) tick();
        vectors++;
        if ({epc_write, iord, exception} !== {1'b1, 1'b1, 4'd1}) begin
            miscompares++;
            $display("FAIL exc2_before_reset epc/iord/exc: got %h want %h",
                     {epc_write, iord, exception}, {1'b1, 1'b1, 4'd1});
        end
        reset = 1'b1;
        #1;
        vectors++;
        if (all_out !== 38'd0) begin
            miscompares++;
            $display("FAIL reset_mid_exc outputs: got %h want 0", all_out);
        end
        repeat (3) begin
            tick();
            vectors++;
            if (all_out !== 38'd0) begin
                miscompares++;
                $display("FAIL reset_mid_exc hold outputs: got %h want 0", all_out);
            end
        end
        reset = 1'b0;
        #1;
        vectors++;
        if (all_out !== {1'b1, 4'd2, 4'd3, 29'd0}) begin
            miscompares++;
            $display("FAIL reset_mid_exc release outputs: got %h want %h", all_out,
                     {1'b1, 4'd2, 4'd3, 29'd0});
        end
    endtask

    task automatic test_random;
        logic [11:0] tbl [16];
        logic [31:0] r;
        logic [5:0]  op, fn;
        int          idx;
        tbl = '{{6'h00, 6'h20}, {6'h00, 6'h22}, {6'h00, 6'h24}, {6'h08, 6'h00},
                {6'h23, 6'h00}, {6'h2B, 6'h00}, {6'h04, 6'h00}, {6'h05, 6'h00},
                {6'h02, 6'h00}, {6'h00, 6'h08}, {6'h00, 6'h13}, {6'h00, 6'h18},
                {6'h00, 6'h1A}, {6'h00, 6'h10}, {6'h00, 6'h12}, {6'h3F, 6'h3F}};
        for (int n = 0; n < 60; n++) begin
            r = $urandom;
            idx = int'(r[3:0]);
            {op, fn} = tbl[idx];
            if (idx == 15) begin
                op = r[9:4];
                fn = r[15:10];
            end
            run_instr("random", op, fn, r[16] & r[17], r[18], r[19] & r[20]);
        end
    endtask

    initial begin
        test_reset();
        test_alu();
        test_branch_jump();
        test_mem();
        test_illegal();
        test_mul_div();
        test_reset_in_exc();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
